// File: rtl/slv_guard_rst_ctrl.sv
// ============================================================================
//  Module   : slv_guard_rst_ctrl
//  Brief    : Timed reset sequencer between the subordinate guard and the
//             protected subordinate, with completion handshake and retry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module slv_guard_rst_ctrl #(
  parameter int ASSERT_CYCLES  = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rst_req_i,
  input  logic                 clear_i,
  output logic                 slv_rst_no,
  output logic                 rst_stat_o,
  output logic                 busy_o,
  output logic                 stuck_o,
  output logic [CNT_WIDTH-1:0] rst_count_o
);

  localparam int c_max_as     = (ASSERT_CYCLES > SETTLE_CYCLES) ? ASSERT_CYCLES : SETTLE_CYCLES;
  localparam int c_max_cycles = (c_max_as > TIMEOUT_CYCLES) ? c_max_as : TIMEOUT_CYCLES;
  localparam int c_timer_w    = $clog2(c_max_cycles + 1);

  localparam logic [c_timer_w-1:0] c_assert_load  = c_timer_w'(ASSERT_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_settle_load  = c_timer_w'(SETTLE_CYCLES - 1);
  localparam logic [c_timer_w-1:0] c_timeout_load = c_timer_w'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_max      = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_SETTLE = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_timer_w-1:0]   r_timer;
  logic                   r_slv_rst_n;
  logic                   r_rst_stat;
  logic                   r_busy;
  logic                   r_stuck;
  logic [CNT_WIDTH-1:0]   r_count;

  logic                   w_timer_zero;
  logic                   w_timeout;
  logic                   w_enter_assert;

  always_comb begin
    w_timer_zero   = (r_timer == '0);
    w_timeout      = (r_state == ST_ACK) && rst_req_i && w_timer_zero;
    w_enter_assert = ((r_state == ST_IDLE) && rst_req_i) || w_timeout;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_slv_rst_n <= 1'b1;
      r_rst_stat  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rst_req_i) begin
            r_state     <= ST_ASSERT;
            r_timer     <= c_assert_load;
            r_slv_rst_n <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_ASSERT: begin
          // Requests arriving here are absorbed, not queued.
          if (w_timer_zero) begin
            r_state     <= ST_SETTLE;
            r_timer     <= c_settle_load;
            r_slv_rst_n <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (w_timer_zero) begin
            r_state    <= ST_ACK;
            r_timer    <= c_timeout_load;
            r_rst_stat <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_ACK: begin
          if (!rst_req_i) begin
            r_state    <= ST_IDLE;
            r_rst_stat <= 1'b0;
            r_busy     <= 1'b0;
          end else if (w_timer_zero) begin
            r_state     <= ST_ASSERT;
            r_timer     <= c_assert_load;
            r_slv_rst_n <= 1'b0;
            r_rst_stat  <= 1'b0;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_timer     <= '0;
          r_slv_rst_n <= 1'b1;
          r_rst_stat  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Clear beats a same-cycle increment; a same-cycle timeout beats clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stuck <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_timeout) begin
        r_stuck <= 1'b1;
      end else if (clear_i) begin
        r_stuck <= 1'b0;
      end

      if (clear_i) begin
        r_count <= '0;
      end else if (w_enter_assert && (r_count != c_cnt_max)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign slv_rst_no  = r_slv_rst_n;
  assign rst_stat_o  = r_rst_stat;
  assign busy_o      = r_busy;
  assign stuck_o     = r_stuck;
  assign rst_count_o = r_count;

endmodule

`default_nettype wire
